// File: rtl/rram_cfg_bank.sv
// DEPTH x DATA_WIDTH bank of 2T2R RRAM cells (bit = r0 | ~r1) with a reset/set programming sequencer.
// Optional build macro RRAM_WRITE_SKIP_EN: program only bits that differ, and skip no-change writes.
module rram_cfg_bank #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 2,
    parameter int PROG_CYCLES = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic [ADDR_WIDTH-1:0]                 req_addr,
    input  logic [DATA_WIDTH-1:0]                 req_data,
    output logic                                  busy,
    output logic                                  done,
    output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] cfg_out,
    output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] cfg_outb
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int TOTAL = DEPTH * DATA_WIDTH;
    localparam int CW    = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(PROG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RST_PH = 2'd1,
        SET_PH = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                  state_r, state_s;
    logic [CW-1:0]           cnt_r, cnt_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   data_r;
    logic [DATA_WIDTH-1:0]   sel_r;
    logic [TOTAL-1:0]        r0_r, r1_r;
    logic [TOTAL-1:0]        wmask_s, wdata_s;
    logic                    accept_s, rst_prog_s, set_prog_s;
    logic                    ready_r, busy_r, done_r;
    logic [DATA_WIDTH-1:0]   sel_s;

    // Live cell readout, no added latency.
    assign cfg_out   = r0_r | ~r1_r;
    assign cfg_outb  = ~cfg_out;
    assign req_ready = ready_r;
    assign busy      = busy_r;
    assign done      = done_r;

`ifdef RRAM_WRITE_SKIP_EN
    logic [DATA_WIDTH-1:0] cur_word_s;
    assign cur_word_s = cfg_out[int'(req_addr)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_s      = req_data ^ cur_word_s;
`else
    assign sel_s      = {DATA_WIDTH{1'b1}};
`endif

    // Sequencer state and phase counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic; phase edges fire when the counter reaches zero.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        accept_s   = 1'b0;
        rst_prog_s = 1'b0;
        set_prog_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    cnt_s    = CNT_LOAD;
                    if (sel_s == {DATA_WIDTH{1'b0}}) begin
                        state_s = DONE;
                    end else begin
                        state_s = RST_PH;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RST_PH: begin
                if (cnt_r == {CW{1'b0}}) begin
                    rst_prog_s = 1'b1;
                    cnt_s      = CNT_LOAD;
                    state_s    = SET_PH;
                end else begin
                    cnt_s = cnt_r - CW'(1);
                end
            end
            SET_PH: begin
                if (cnt_r == {CW{1'b0}}) begin
                    set_prog_s = 1'b1;
                    state_s    = DONE;
                end else begin
                    cnt_s = cnt_r - CW'(1);
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Request latch; frozen for the whole write so input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r <= {ADDR_WIDTH{1'b0}};
            data_r <= {DATA_WIDTH{1'b0}};
            sel_r  <= {DATA_WIDTH{1'b0}};
        end else if (accept_s) begin
            addr_r <= req_addr;
            data_r <= req_data;
            sel_r  <= sel_s;
        end else begin
            addr_r <= addr_r;
            data_r <= data_r;
            sel_r  <= sel_r;
        end
    end

    // Place the selected-bit mask and target data at the latched word position.
    always_comb begin
        wmask_s = {TOTAL{1'b0}};
        wdata_s = {TOTAL{1'b0}};
        wmask_s[int'(addr_r)*DATA_WIDTH +: DATA_WIDTH] = sel_r;
        wdata_s[int'(addr_r)*DATA_WIDTH +: DATA_WIDTH] = data_r;
    end

    // Cell array: reset phase clears one resistor, set phase programs the other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_r <= {TOTAL{1'b0}};
            r1_r <= {TOTAL{1'b1}};
        end else if (rst_prog_s) begin
            r1_r <= r1_r & ~(wmask_s & wdata_s);
            r0_r <= r0_r & ~(wmask_s & ~wdata_s);
        end else if (set_prog_s) begin
            r0_r <= r0_r | (wmask_s & wdata_s);
            r1_r <= r1_r | (wmask_s & ~wdata_s);
        end else begin
            r0_r <= r0_r;
            r1_r <= r1_r;
        end
    end

    // Status outputs registered from the next state so they track state_r exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ready_r <= (state_s == IDLE);
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
        end
    end

endmodule

// File: tb/tb_rram_cfg_bank.sv
// Self-checking bench for rram_cfg_bank: table of writes plus hand-written reset/busy/skip sequences.
module tb_rram_cfg_bank;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int P     = 4;
    localparam int DEPTH = 4;
    localparam int TOT   = DEPTH * DW;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [AW-1:0]  req_addr;
    logic [DW-1:0]  req_data;
    logic           busy;
    logic           done;
    logic [TOT-1:0] cfg_out;
    logic [TOT-1:0] cfg_outb;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] model [DEPTH];

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] mid;
        logic [DW-1:0] fin;
    } vec_t;
    vec_t vt [7];

    rram_cfg_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PROG_CYCLES(P)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .busy(busy), .done(done),
        .cfg_out(cfg_out), .cfg_outb(cfg_outb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [TOT-1:0] image(input int a, input logic [DW-1:0] w, input bit use_w);
        logic [TOT-1:0] img;
        for (int i = 0; i < DEPTH; i++)
            img[i*DW +: DW] = (use_w && i == a) ? w : model[i];
        return img;
    endfunction

    task automatic do_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] mid, input logic [DW-1:0] fin, input bit hold);
        int bad;
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        chk({tag, "_ready_pre"}, TOT'(req_ready), TOT'(1));
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        chk({tag, "_busy"}, TOT'(busy), TOT'(1));
        chk({tag, "_ready_busy"}, TOT'(req_ready), TOT'(0));
        bad = 0;
        for (int i = 1; i <= 2*P+1; i++) begin
            @(posedge clk); #1;
            if (done !== ((i == 2*P) ? 1'b1 : 1'b0)) bad++;
            if (i == P) begin
                chk({tag, "_mid"}, cfg_out, image(int'(a), mid, 1'b1));
                chk({tag, "_midb"}, cfg_outb, ~image(int'(a), mid, 1'b1));
            end
            if (i == 2*P) begin
                chk({tag, "_fin"}, cfg_out, image(int'(a), fin, 1'b1));
                chk({tag, "_finb"}, cfg_outb, ~image(int'(a), fin, 1'b1));
            end
        end
        chk({tag, "_done_pulse"}, TOT'(bad), TOT'(0));
        chk({tag, "_ready_back"}, TOT'(req_ready), TOT'(1));
        model[a] = fin;
    endtask

    initial begin
        int bad;
        int lat;
        vt[0] = '{2'd3, 8'hA5, 8'hA5, 8'hA5};
        vt[1] = '{2'd3, 8'h0F, 8'hAF, 8'h0F};
        vt[2] = '{2'd0, 8'h3C, 8'h3C, 8'h3C};
        vt[3] = '{2'd0, 8'hC3, 8'hFF, 8'hC3};
        vt[4] = '{2'd1, 8'h81, 8'h81, 8'h81};
        vt[5] = '{2'd2, 8'h7E, 8'h7E, 8'h7E};
        vt[6] = '{2'd1, 8'h18, 8'h99, 8'h18};
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;

        rst = 1'b0; req_valid = 1'b0; req_addr = 2'd0; req_data = 8'h00;
        #2 rst = 1'b1;
        #1;
        chk("rst_cfg_out", cfg_out, {TOT{1'b0}});
        chk("rst_cfg_outb", cfg_outb, {TOT{1'b1}});
        chk("rst_ready", TOT'(req_ready), TOT'(1));
        chk("rst_busy", TOT'(busy), TOT'(0));
        chk("rst_done", TOT'(done), TOT'(0));
        @(posedge clk); #1 rst = 1'b0;

        for (int k = 0; k < 7; k++)
            do_write($sformatf("vec%0d", k), vt[k].a, vt[k].d, vt[k].mid, vt[k].fin, 1'b0);

        // Held request: only one accept per write, then back-to-back second write.
        do_write("hold_a", 2'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        chk("hold_idle_busy", TOT'(busy), TOT'(0));
        do_write("hold_b", 2'd0, 8'h5A, 8'hFF, 8'h5A, 1'b0);

        // Reset in the middle of a write, with word 2 already holding 0x3C.
        do_write("pre_rst", 2'd2, 8'h3C, 8'h7E, 8'h3C, 1'b0);
        req_addr = 2'd1; req_data = 8'h55; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
        chk("midrst_cfg_out", cfg_out, {TOT{1'b0}});
        chk("midrst_cfg_outb", cfg_outb, {TOT{1'b1}});
        chk("midrst_ready", TOT'(req_ready), TOT'(1));
        chk("midrst_busy", TOT'(busy), TOT'(0));
        @(posedge clk); #1 rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 2*P+2; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("midrst_no_done", TOT'(bad), TOT'(0));
        do_write("post_rst", 2'd1, 8'h55, 8'h55, 8'h55, 1'b0);

        // Rewrite of an identical value: latency depends on the skip build.
        do_write("skip_pre", 2'd3, 8'h0F, 8'h0F, 8'h0F, 1'b0);
        req_addr = 2'd3; req_data = 8'h0F; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            if (done === 1'b1) lat = i;
            else begin @(posedge clk); #1; end
        end
`ifdef RRAM_WRITE_SKIP_EN
        chk("skip_latency", TOT'(lat), TOT'(0));
`else
        chk("skip_latency", TOT'(lat), TOT'(2*P));
`endif
        chk("skip_word", cfg_out, image(0, 8'h00, 1'b0));
        @(posedge clk); #1;
        chk("skip_done_low", TOT'(done), TOT'(0));
        chk("skip_ready", TOT'(req_ready), TOT'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rram_cfg_bank.md
# rram_cfg_bank

Parametrised configuration-memory bank of 2T2R RRAM bit cells, with a programming sequencer that applies timed reset/set phases per written word. It generalises the single complementary RRAM cell (dout = r0 | ~r1) to DEPTH words of DATA_WIDTH bits. The request handshake replaces the raw BL/WL pulses. The bank sits between the bitstream loader and the FPGA fabric, and drives all configuration bits in parallel.

## Interface
- DATA_WIDTH, 8: bits per word.
- ADDR_WIDTH, 2: address bits; DEPTH = 2**ADDR_WIDTH words.
- PROG_CYCLES, 4: length in clocks of each programming phase; must be ≥ 1.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  write request valid.
- req_ready  out  1  bank can accept a request.
- req_addr  in  ADDR_WIDTH  target word.
- req_data  in  DATA_WIDTH  value to program.
- busy  out  1  sequencer not in IDLE.
- done  out  1  one-cycle pulse when a write completes.
- cfg_out  out  DEPTH*DATA_WIDTH  live cell outputs; word i at [i*DATA_WIDTH +: DATA_WIDTH].
- cfg_outb  out  DEPTH*DATA_WIDTH  bitwise ~cfg_out.

## Operation
- Cell state per bit is the register pair (r0, r1); the bit value is r0 | ~r1.
- Erased cell: r0=0, r1=1, bit value 0.
- Programmed-1 cell: r0=1, r1=0.
- Programmed-0 cell: r0=0, r1=1.
- FSM states: IDLE, RST_PH, SET_PH, DONE.
- IDLE: req_ready=1, busy=0. On req_valid && req_ready, latch addr and data, load the phase counter with PROG_CYCLES-1, then go to RST_PH.
- RST_PH lasts PROG_CYCLES cycles. On its last edge, every selected bit is reset-programmed:
  - target 1: r1←0
  - target 0: r0←0
  Then go to SET_PH.
- SET_PH lasts PROG_CYCLES cycles. On its last edge, every selected bit is set-programmed:
  - target 1: r0←1
  - target 0: r1←1
  Then go to DONE.
- DONE lasts one cycle: done=1, busy=1, req_ready=0. Then go to IDLE.
- The selected bits are all DATA_WIDTH bits of the word, unless RRAM_WRITE_SKIP_EN changes this.
- Word value after RST_PH is old | new. Word value after SET_PH is new. Unselected bits and other words never change.
- While not in IDLE, req_ready=0 and req_valid is ignored; the latched addr/data are not affected by input changes.

## Timing
- Reset values: all cells erased (cfg_out all 0, cfg_outb all 1), FSM in IDLE, req_ready=1, busy=0, done=0.
- Reset asserted mid-write: the FSM returns to IDLE immediately and all words are erased, including words that already completed.
- Cycle numbering: request accepted at edge E0.
  - busy=1 from E0.
  - Intermediate value (old | new) visible after edge E0+PROG_CYCLES.
  - Final value visible after edge E0+2*PROG_CYCLES.
  - done high for the cycle following that edge.
  - req_ready high again after edge E0+2*PROG_CYCLES+1.
- Back-to-back writes: a new request can be accepted at the first edge where req_ready=1. Minimum spacing is therefore 2*PROG_CYCLES+2 edges.
- cfg_out and cfg_outb are combinational from the cell registers, with no added latency.

## Configuration
- Macro: RRAM_WRITE_SKIP_EN.
- Defined:
  - Selected bits are only those where the latched data differs from the current word value at acceptance.
  - If no bit differs, the FSM goes IDLE→DONE at the accept edge. done is then high in the next cycle, so total latency is 1 cycle with no phases.
- Undefined: all bits of the word are programmed every write, and timing is always 2*PROG_CYCLES+2.
- Word value sequences (old | new, then new) are identical in both builds. Only latency and pulse count differ.

## Test plan
- Reset check (defaults): assert rst asynchronously between edges.
  - Immediately: cfg_out=0x00000000, cfg_outb all ones, req_ready=1, busy=0, done=0.
- First write, PROG_CYCLES=4: write addr=3, data=0xA5 at E0.
  - Word 3 = 0xA5 after E0+4 and still after E0+8.
  - done high exactly one cycle, after E0+8; req_ready back after E0+9.
  - Words 0–2 stay 0.
- Overwrite, intermediate value: write addr=3 data=0x0F over 0xA5.
  - Word 3 = 0xAF after the RST phase, then 0x0F after the SET phase.
- Busy rejection: hold req_valid=1 with addr=0 data=0xFF for the whole write.
  - Only the first request is accepted; word 0 = 0xFF.
  - A second write starts only after req_ready returns, with exactly one done per accepted request.
- Reset mid-write: assert rst at E0+5 of a write to addr 1 with word 2 already 0x3C.
  - All words read 0, FSM in IDLE, no done pulse.
  - A new write after release completes normally.
- Write-skip (RRAM_WRITE_SKIP_EN): rewrite addr=3 data=0x0F onto 0x0F.
  - done one cycle after accept, word unchanged.
  - Without the macro, the same stimulus takes 2*PROG_CYCLES+2 cycles with the same final value.
